// File: rtl/bht_pkg.sv
// Shared types and defaults for the BHT branch predictor.
// Counter encoding: 00 strongly not-taken up to 11 strongly taken.
package bht_pkg;

    localparam int DEFAULT_INDEX_BITS = 4;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

endpackage

// File: rtl/sat_counter2.sv
// Combinational next state of a 2-bit saturating branch counter.
module sat_counter2
    import bht_pkg::*;
(
    input  ctr_t state,
    input  logic taken,
    output ctr_t next_state
);

    always_comb begin
        next_state = state;
        case (state)
            SNT: next_state = taken ? WNT : SNT;
            WNT: next_state = taken ? WT  : SNT;
            WT:  next_state = taken ? ST  : WNT;
            ST:  next_state = taken ? ST  : WT;
            default: next_state = state;
        endcase
    end

endmodule

// File: rtl/bht_branch_predictor.sv
// Fetch-stage 2-bit counter branch predictor with registered prediction and target.
// Define BHT_GSHARE_EN to XOR a global outcome history into both table indices.
module bht_branch_predictor
    import bht_pkg::*;
#(
    parameter int         INDEX_BITS = DEFAULT_INDEX_BITS,
    parameter logic [1:0] INIT_STATE = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic [31:0] offset_in,
    input  logic        is_branch_in,
    input  logic        update_valid_in,
    input  logic [31:0] update_pc_in,
    input  logic        update_taken_in,
    output logic        predict_out,
    output logic [31:0] target_out,
    output logic        valid_out
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    ctr_t                  table_q [ENTRIES];
    logic [INDEX_BITS-1:0] rd_idx;
    logic [INDEX_BITS-1:0] wr_idx;
    ctr_t                  wr_next;

    // Only the index field of the update PC is meaningful; the rest is dropped on purpose.
    logic unused_update_pc_bits;
    assign unused_update_pc_bits = ^{update_pc_in[31:INDEX_BITS+2], update_pc_in[1:0]};

`ifdef BHT_GSHARE_EN
    logic [INDEX_BITS-1:0] ghr;

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr <= '0;
        end else if (update_valid_in) begin
            ghr <= {ghr[INDEX_BITS-2:0], update_taken_in};
        end
    end

    // Both indices use the history as it stood before this cycle's update.
    assign rd_idx = pc_in[INDEX_BITS+1:2] ^ ghr;
    assign wr_idx = update_pc_in[INDEX_BITS+1:2] ^ ghr;
`else
    assign rd_idx = pc_in[INDEX_BITS+1:2];
    assign wr_idx = update_pc_in[INDEX_BITS+1:2];
`endif

    sat_counter2 u_sat_counter2 (
        .state      (table_q[wr_idx]),
        .taken      (update_taken_in),
        .next_state (wr_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= ctr_t'(INIT_STATE);
            end
        end else if (update_valid_in) begin
            table_q[wr_idx] <= wr_next;
        end
    end

    // Reads see the pre-update counter, so a same-cycle update shows up one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            predict_out <= 1'b0;
            target_out  <= 32'b0;
            valid_out   <= 1'b0;
        end else begin
            predict_out <= is_branch_in & table_q[rd_idx][1];
            target_out  <= pc_in + offset_in;
            valid_out   <= is_branch_in;
        end
    end

endmodule

// File: tb/tb_bht_branch_predictor.sv
// Scoreboard bench for bht_branch_predictor against a table-of-integers reference model.
module tb_bht_branch_predictor;

    typedef struct packed {
        logic        predict;
        logic [31:0] target;
        logic        valid;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] pc_in;
    logic [31:0] offset_in;
    logic        is_branch_in;
    logic        update_valid_in;
    logic [31:0] update_pc_in;
    logic        update_taken_in;
    logic        predict_out;
    logic [31:0] target_out;
    logic        valid_out;

    exp_t  exp_q[$];
    string name_q[$];

    int tests_run    = 0;
    int tests_failed = 0;

    // Model state: counter strength 0..3 per entry and the outcome history.
    int model_ctr [16];
    int model_ghr;

    bht_branch_predictor dut (
        .clk             (clk),
        .rst             (rst),
        .pc_in           (pc_in),
        .offset_in       (offset_in),
        .is_branch_in    (is_branch_in),
        .update_valid_in (update_valid_in),
        .update_pc_in    (update_pc_in),
        .update_taken_in (update_taken_in),
        .predict_out     (predict_out),
        .target_out      (target_out),
        .valid_out       (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_index(input logic [31:0] pc);
        int idx;
        idx = int'((pc / 4) % 16);
`ifdef BHT_GSHARE_EN
        idx = idx ^ model_ghr;
`endif
        return idx;
    endfunction

    task automatic applyStimulus(input string name, input bit rst_v,
                                 input logic [31:0] pc, input logic [31:0] off, input bit br,
                                 input bit uv, input logic [31:0] upc, input bit ut);
        exp_t e;
        int   ri;
        int   wi;
        @(negedge clk);
        rst             = rst_v;
        pc_in           = pc;
        offset_in       = off;
        is_branch_in    = br;
        update_valid_in = uv;
        update_pc_in    = upc;
        update_taken_in = ut;
        if (rst_v) begin
            e = '0;
            for (int i = 0; i < 16; i++) model_ctr[i] = 1;
            model_ghr = 0;
        end else begin
            ri = model_index(pc);
            e.predict = br && (model_ctr[ri] >= 2);
            e.target  = pc + off;
            e.valid   = br;
            if (uv) begin
                wi = model_index(upc);
                if (ut) model_ctr[wi] = (model_ctr[wi] == 3) ? 3 : model_ctr[wi] + 1;
                else    model_ctr[wi] = (model_ctr[wi] == 0) ? 0 : model_ctr[wi] - 1;
                model_ghr = ((model_ghr * 2) + (ut ? 1 : 0)) % 16;
            end
        end
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    task automatic checkOutput(input string name, input exp_t e);
        tests_run++;
        if (predict_out !== e.predict) begin
            tests_failed++;
            $display("[TB] FAIL %s predict: got %0b want %0b", name, predict_out, e.predict);
        end
        tests_run++;
        if (target_out !== e.target) begin
            tests_failed++;
            $display("[TB] FAIL %s target: got %h want %h", name, target_out, e.target);
        end
        tests_run++;
        if (valid_out !== e.valid) begin
            tests_failed++;
            $display("[TB] FAIL %s valid: got %0b want %0b", name, valid_out, e.valid);
        end
    endtask

    // Monitor: outputs are registered every cycle, so one expectation is retired per edge.
    initial begin
        exp_t  e;
        string n;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checkOutput(n, e);
            end
        end
    end

    task automatic train(input string name, input logic [31:0] upc, input bit ut);
        applyStimulus(name, 0, 32'h0, 32'h0, 0, 1, upc, ut);
    endtask

    task automatic predict(input string name, input logic [31:0] pc);
        applyStimulus(name, 0, pc, 32'h40, 1, 0, 32'h0, 0);
    endtask

    initial begin
        logic [31:0] rpc;
        logic [31:0] rupc;
        rst = 1'b1; pc_in = '0; offset_in = '0; is_branch_in = 0;
        update_valid_in = 0; update_pc_in = '0; update_taken_in = 0;
        for (int i = 0; i < 16; i++) model_ctr[i] = 1;
        model_ghr = 0;

        applyStimulus("reset", 1, 32'h0, 32'h0, 0, 0, 32'h0, 0);
        applyStimulus("reset2", 1, 32'h0, 32'h0, 0, 0, 32'h0, 0);
        applyStimulus("first_predict", 0, 32'h100, 32'h20, 1, 0, 32'h0, 0);
        applyStimulus("no_branch", 0, 32'h100, 32'h20, 0, 0, 32'h0, 0);

        train("train_t1", 32'h100, 1);
        train("train_t2", 32'h100, 1);
        predict("pred_strong", 32'h100);
        train("train_nt1", 32'h100, 0);
        predict("pred_weak_taken", 32'h100);
        train("train_nt2", 32'h100, 0);
        predict("pred_weak_not", 32'h100);

        applyStimulus("reset_rbw", 1, 32'h0, 32'h0, 0, 0, 32'h0, 0);
        applyStimulus("rbw_same", 0, 32'h100, 32'h8, 1, 1, 32'h100, 1);
        predict("rbw_next", 32'h100);

        applyStimulus("reset_alias", 1, 32'h0, 32'h0, 0, 0, 32'h0, 0);
        train("alias_t1", 32'h104, 1);
        train("alias_t2", 32'h104, 1);
        predict("alias_pred", 32'h144);
        applyStimulus("wrap", 0, 32'hFFFFFFF0, 32'h20, 1, 0, 32'h0, 0);
        applyStimulus("low_bits", 0, 32'h107, 32'h0, 1, 1, 32'h203, 0);

        train("st_t1", 32'h100, 1);
        train("st_t2", 32'h100, 1);
        train("st_t3", 32'h100, 1);
        applyStimulus("reset_mid_update", 1, 32'h100, 32'h4, 1, 1, 32'h100, 1);
        predict("after_reset", 32'h100);

        applyStimulus("reset_hist", 1, 32'h0, 32'h0, 0, 0, 32'h0, 0);
        train("hist_seed", 32'h200, 1);
        train("hist_t1", 32'h100, 1);
        train("hist_t2", 32'h100, 1);
        predict("hist_pred", 32'h100);

        for (int i = 0; i < 3; i++) predict("stall_hold", 32'h13C);

        for (int i = 0; i < 400; i++) begin
            rpc  = {$urandom_range(0, 3), 24'h0, 6'($urandom_range(0, 63)), 2'($urandom)};
            rupc = {$urandom_range(0, 3), 24'h0, 6'($urandom_range(0, 63)), 2'($urandom)};
            applyStimulus("random", ($urandom_range(0, 49) == 0), rpc, $urandom,
                          1'($urandom), 1'($urandom), rupc, 1'($urandom));
        end

        @(posedge clk);
        #2;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
